// File: rtl/QuplsMmupkg.sv
// MMU types: page-table entries, TLB entries and DTLB miss bookkeeping.
package QuplsMmupkg;

   localparam int MISS_HOLD = 63;

   typedef logic [7:0] asid_t;

   typedef struct packed {
      logic        v;
      logic        u;
      logic [2:0]  rwx;
      logic [2:0]  rsvd;
      logic [15:0] ppn;
   } spte_t;

   typedef struct packed {
      asid_t      asid;
      logic [8:0] vpn;
   } tlb_vpn_t;

   typedef struct packed {
      spte_t    pte;
      tlb_vpn_t vpn;
   } tlb_entry_t;

   // Outstanding miss key: {asid, adr[31:16]} of the last request sent to the walker.
   typedef struct packed {
      logic        v;
      asid_t       asid;
      logic [15:0] adr;
   } dtlb_pending_t;

endpackage

// File: rtl/QuplsPkg.sv
// Core-wide scalar types shared by the Qupls pipeline blocks.
package QuplsPkg;

   typedef logic [31:0] address_t;
   typedef logic [31:0] physical_address_t;
   typedef logic [5:0]  rob_ndx_t;

endpackage

// File: rtl/qupls_dtlb_way.sv
// One DTLB way: entry storage with a registered read port, sync fill port,
// and per-entry valid bits that support full and per-ASID invalidation.
module qupls_dtlb_way
   import QuplsMmupkg::*;
#(
   parameter  int SETS  = 128,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [IDX_W-1:0] wr_idx,
   input  tlb_entry_t       wr_entry,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic             flush_all,
   input  logic             flush_asid_v,
   input  asid_t            flush_asid,
   output logic             rd_valid,
   output tlb_entry_t       rd_entry
);

   tlb_entry_t       mem [SETS];
   logic [SETS-1:0]  valid;

   // NOTE: entry storage is deliberately not reset; the valid bits alone gate its use.
   always_ff @(posedge clk) begin
      if (wr)
         mem[wr_idx] <= wr_entry;
      rd_entry <= mem[rd_idx];
   end

   // A fill issued in a flush cycle is applied last so it survives the flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= '0;
         rd_valid <= 1'b0;
      end else begin
         for (int i = 0; i < SETS; i++)
            if (flush_all || (flush_asid_v && mem[i].vpn.asid == flush_asid))
               valid[i] <= 1'b0;
         if (wr)
            valid[wr_idx] <= 1'b1;
         rd_valid <= valid[rd_idx];
      end
   end

endmodule

// File: rtl/qupls_dtlb.sv
// Two-way set-associative data TLB (64 KB pages) feeding misses to the
// page-table walker and accepting walker fills.
module qupls_dtlb
   import QuplsPkg::*;
   import QuplsMmupkg::*;
#(
   parameter  int SETS  = 128,
   localparam int IDX_W = $clog2(SETS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              lookup_v,
   input  address_t          lookup_adr,
   input  asid_t             lookup_asid,
   input  rob_ndx_t          lookup_id,
   input  logic [1:0]        lookup_qn,
   output logic              res_v,
   output logic              res_hit,
   output physical_address_t res_padr,
   output spte_t             res_pte,
   output logic              tlbmiss,
   output address_t          tlb_missadr,
   output asid_t             tlb_missasid,
   output rob_ndx_t          tlb_missid,
   output logic [1:0]        tlb_missqn,
   input  logic              in_que,
   input  logic              tlb_wr,
   input  logic              tlb_way,
   input  logic [IDX_W-1:0]  tlb_entryno,
   input  tlb_entry_t        tlb_entry,
   input  logic              flush_all,
   input  logic              flush_asid_v,
   input  asid_t             flush_asid
);

   localparam int CNT_W = $clog2(MISS_HOLD + 1);

   logic          req_v;
   address_t      req_adr;
   asid_t         req_asid;
   rob_ndx_t      req_id;
   logic [1:0]    req_qn;

   logic          way_valid [2];
   tlb_entry_t    way_entry [2];
   logic [1:0]    way_hit;
   logic          hit;
   spte_t         hit_pte;

   dtlb_pending_t pend;
   logic [CNT_W-1:0] hold_cnt;
   logic          wr_same;
   logic          pend_same;
   logic          pend_clr;

   for (genvar w = 0; w < 2; w++) begin : g_way
      qupls_dtlb_way #(.SETS(SETS)) u_way (
         .clk          (clk),
         .rst          (rst),
         .wr           (tlb_wr && tlb_way == 1'(w)),
         .wr_idx       (tlb_entryno),
         .wr_entry     (tlb_entry),
         .rd_idx       (lookup_adr[16 +: IDX_W]),
         .flush_all    (flush_all),
         .flush_asid_v (flush_asid_v),
         .flush_asid   (flush_asid),
         .rd_valid     (way_valid[w]),
         .rd_entry     (way_entry[w])
      );
      assign way_hit[w] = way_valid[w] && way_entry[w].pte.v
                          && way_entry[w].vpn.vpn == req_adr[31:23]
                          && way_entry[w].vpn.asid == req_asid;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_v    <= 1'b0;
         req_adr  <= '0;
         req_asid <= '0;
         req_id   <= '0;
         req_qn   <= '0;
      end else begin
         req_v    <= lookup_v;
         req_adr  <= lookup_adr;
         req_asid <= lookup_asid;
         req_id   <= lookup_id;
         req_qn   <= lookup_qn;
      end
   end

   // Way 0 has priority when both ways hold a matching translation.
   always_comb begin
      hit     = 1'b0;
      hit_pte = '0;
      if (req_v && way_hit[0]) begin
         hit     = 1'b1;
         hit_pte = way_entry[0].pte;
      end else if (req_v && way_hit[1]) begin
         hit     = 1'b1;
         hit_pte = way_entry[1].pte;
      end
   end

   assign res_v    = req_v;
   assign res_hit  = hit;
   assign res_pte  = hit_pte;
   assign res_padr = hit ? {hit_pte.ppn, req_adr[15:0]} : '0;

   // A miss is not re-sent while the walker still owns it or is filling it right now.
   assign wr_same   = tlb_wr && tlb_entryno == req_adr[16 +: IDX_W]
                      && tlb_entry.vpn.vpn == req_adr[31:23]
                      && tlb_entry.vpn.asid == req_asid;
   assign pend_same = pend.v && pend.asid == req_asid && pend.adr == req_adr[31:16];
   assign tlbmiss   = req_v && !hit && !pend_same && !wr_same;

   assign tlb_missadr  = req_adr;
   assign tlb_missasid = req_asid;
   assign tlb_missid   = req_id;
   assign tlb_missqn   = req_qn;

   assign pend_clr = flush_all
                     || (flush_asid_v && flush_asid == pend.asid)
                     || (tlb_wr && tlb_entryno == pend.adr[IDX_W-1:0]
                         && tlb_entry.vpn.vpn == pend.adr[15:7]
                         && tlb_entry.vpn.asid == pend.asid);

   // NOTE: later non-blocking assignments override earlier ones, so a new miss beats any clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= '0;
         hold_cnt <= '0;
      end else begin
         if (pend.v) begin
            if (in_que)
               hold_cnt <= CNT_W'(MISS_HOLD);
            else begin
               hold_cnt <= hold_cnt - 1'b1;
               if (hold_cnt == CNT_W'(1))
                  pend.v <= 1'b0;
            end
         end
         if (pend_clr)
            pend.v <= 1'b0;
         if (tlbmiss) begin
            pend     <= '{v: 1'b1, asid: req_asid, adr: req_adr[31:16]};
            hold_cnt <= CNT_W'(MISS_HOLD);
         end
      end
   end

endmodule

// File: tb/tb_qupls_dtlb.sv
// Directed plus randomized bench for qupls_dtlb against an array-based TLB model.
module tb_qupls_dtlb;
   import QuplsPkg::*;
   import QuplsMmupkg::*;

   localparam int SETS = 128;

   logic              clk;
   logic              rst;
   logic              lookup_v;
   address_t          lookup_adr;
   asid_t             lookup_asid;
   rob_ndx_t          lookup_id;
   logic [1:0]        lookup_qn;
   logic              res_v;
   logic              res_hit;
   physical_address_t res_padr;
   spte_t             res_pte;
   logic              tlbmiss;
   address_t          tlb_missadr;
   asid_t             tlb_missasid;
   rob_ndx_t          tlb_missid;
   logic [1:0]        tlb_missqn;
   logic              in_que;
   logic              tlb_wr;
   logic              tlb_way;
   logic [6:0]        tlb_entryno;
   tlb_entry_t        tlb_entry;
   logic              flush_all;
   logic              flush_asid_v;
   asid_t             flush_asid;

   qupls_dtlb #(.SETS(SETS)) dut (
      .clk          (clk),
      .rst          (rst),
      .lookup_v     (lookup_v),
      .lookup_adr   (lookup_adr),
      .lookup_asid  (lookup_asid),
      .lookup_id    (lookup_id),
      .lookup_qn    (lookup_qn),
      .res_v        (res_v),
      .res_hit      (res_hit),
      .res_padr     (res_padr),
      .res_pte      (res_pte),
      .tlbmiss      (tlbmiss),
      .tlb_missadr  (tlb_missadr),
      .tlb_missasid (tlb_missasid),
      .tlb_missid   (tlb_missid),
      .tlb_missqn   (tlb_missqn),
      .in_que       (in_que),
      .tlb_wr       (tlb_wr),
      .tlb_way      (tlb_way),
      .tlb_entryno  (tlb_entryno),
      .tlb_entry    (tlb_entry),
      .flush_all    (flush_all),
      .flush_asid_v (flush_asid_v),
      .flush_asid   (flush_asid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: contents per way/set, the in-flight lookup, and the outstanding miss.
   logic        m_v [2][SETS];
   tlb_entry_t  m_e [2][SETS];
   logic        p_v;
   address_t    p_adr;
   asid_t       p_asid;
   rob_ndx_t    p_id;
   logic [1:0]  p_qn;
   logic        p_hit;
   spte_t       p_pte;
   logic        pd_v;
   asid_t       pd_asid;
   logic [15:0] pd_adr;
   int          pd_ref;
   int          cyc = 0;

   int          pulses = 0;
   int          last_miss_cyc = 0;
   address_t    last_missadr;
   asid_t       last_missasid;
   rob_ndx_t    last_missid;
   logic [1:0]  last_missqn;
   logic        last_hit;
   physical_address_t last_padr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic tlb_entry_t mk_entry(logic [8:0] vpn, asid_t asid, logic [15:0] ppn, logic v);
      tlb_entry_t e;
      e          = '0;
      e.vpn.vpn  = vpn;
      e.vpn.asid = asid;
      e.pte.v    = v;
      e.pte.rwx  = 3'b011;
      e.pte.ppn  = ppn;
      return e;
   endfunction

   task automatic model_reset();
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < SETS; i++)
            m_v[w][i] = 1'b0;
      p_v  = 1'b0;
      p_hit = 1'b0;
      p_pte = '0;
      pd_v = 1'b0;
   endtask

   task automatic idle();
      lookup_v     = 1'b0;
      lookup_adr   = '0;
      lookup_asid  = '0;
      lookup_id    = '0;
      lookup_qn    = '0;
      in_que       = 1'b0;
      tlb_wr       = 1'b0;
      tlb_way      = 1'b0;
      tlb_entryno  = '0;
      tlb_entry    = '0;
      flush_all    = 1'b0;
      flush_asid_v = 1'b0;
      flush_asid   = '0;
   endtask

   task automatic set_lookup(input address_t a, input asid_t s, input rob_ndx_t id, input logic [1:0] qn);
      lookup_v    = 1'b1;
      lookup_adr  = a;
      lookup_asid = s;
      lookup_id   = id;
      lookup_qn   = qn;
   endtask

   task automatic set_fill(input logic way, input logic [6:0] no, input tlb_entry_t e);
      tlb_wr      = 1'b1;
      tlb_way     = way;
      tlb_entryno = no;
      tlb_entry   = e;
   endtask

   // Called just after a falling edge with this cycle's inputs driven; returns at the next falling edge.
   task automatic step();
      logic exp_miss, wr_match, pend_match, clr, active;
      int   idx;
      #1;
      active     = pd_v && (cyc - pd_ref <= MISS_HOLD);
      wr_match   = tlb_wr && tlb_entryno == p_adr[22:16] && tlb_entry.vpn.vpn == p_adr[31:23]
                   && tlb_entry.vpn.asid == p_asid;
      pend_match = active && pd_asid == p_asid && pd_adr == p_adr[31:16];
      exp_miss   = p_v && !p_hit && !pend_match && !wr_match;

      check("res_v", res_v, p_v);
      if (p_v) begin
         check("res_hit", res_hit, p_hit);
         check("res_padr", res_padr, p_hit ? {p_pte.ppn, p_adr[15:0]} : 32'h0);
         check("res_pte", res_pte, p_hit ? p_pte : '0);
      end
      check("tlbmiss", tlbmiss, exp_miss);
      if (exp_miss) begin
         check("missadr", tlb_missadr, p_adr);
         check("missasid", tlb_missasid, p_asid);
         check("missid", tlb_missid, p_id);
         check("missqn", tlb_missqn, p_qn);
      end
      if (res_v) begin
         last_hit  = res_hit;
         last_padr = res_padr;
      end
      if (tlbmiss) begin
         pulses++;
         last_miss_cyc = cyc;
         last_missadr  = tlb_missadr;
         last_missasid = tlb_missasid;
         last_missid   = tlb_missid;
         last_missqn   = tlb_missqn;
      end

      if (active && in_que)
         pd_ref = cyc;
      clr = flush_all || (flush_asid_v && flush_asid == pd_asid)
            || (tlb_wr && tlb_entryno == pd_adr[6:0] && tlb_entry.vpn.vpn == pd_adr[15:7]
                && tlb_entry.vpn.asid == pd_asid);
      if (clr)
         pd_v = 1'b0;
      if (exp_miss) begin
         pd_v    = 1'b1;
         pd_asid = p_asid;
         pd_adr  = p_adr[31:16];
         pd_ref  = cyc;
      end

      p_v    = lookup_v;
      p_adr  = lookup_adr;
      p_asid = lookup_asid;
      p_id   = lookup_id;
      p_qn   = lookup_qn;
      p_hit  = 1'b0;
      p_pte  = '0;
      idx    = int'(lookup_adr[22:16]);
      if (lookup_v)
         for (int w = 1; w >= 0; w--)
            if (m_v[w][idx] && m_e[w][idx].pte.v && m_e[w][idx].vpn.vpn == lookup_adr[31:23]
                && m_e[w][idx].vpn.asid == lookup_asid) begin
               p_hit = 1'b1;
               p_pte = m_e[w][idx].pte;
            end

      for (int w = 0; w < 2; w++)
         for (int i = 0; i < SETS; i++)
            if (flush_all || (flush_asid_v && m_e[w][i].vpn.asid == flush_asid))
               m_v[w][i] = 1'b0;
      if (tlb_wr) begin
         m_e[int'(tlb_way)][int'(tlb_entryno)] = tlb_entry;
         m_v[int'(tlb_way)][int'(tlb_entryno)] = 1'b1;
      end

      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic look_once(input address_t a, input asid_t s, output logic hit);
      idle();
      set_lookup(a, s, 6'd1, 2'd0);
      step();
      idle();
      step();
      hit = last_hit;
   endtask

   function automatic logic [6:0] pick_set();
      case ($urandom % 4)
         0:       return 7'h12;
         1:       return 7'h13;
         2:       return 7'h40;
         default: return 7'h7F;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic h;
      int   p0;
      address_t a;

      for (int w = 0; w < 2; w++)
         for (int i = 0; i < SETS; i++)
            m_e[w][i] = '0;
      idle();
      rst = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_res_v", res_v, 1'b0);
      check("reset_res_hit", res_hit, 1'b0);
      check("reset_tlbmiss", tlbmiss, 1'b0);
      check("reset_res_padr", res_padr, 32'h0);
      check("reset_missadr", tlb_missadr, 32'h0);
      rst = 1'b1;
      idle();
      step();

      // Cold miss
      p0 = pulses;
      set_lookup(32'h0012_3456, 8'd5, 6'd3, 2'd1);
      step();
      idle();
      step();
      check("cold_pulse", pulses - p0, 1);
      check("cold_hit", last_hit, 1'b0);
      check("cold_missadr", last_missadr, 32'h0012_3456);
      check("cold_missasid", last_missasid, 8'd5);
      check("cold_missid", last_missid, 6'd3);
      check("cold_missqn", last_missqn, 2'd1);

      // Fill then hit
      set_fill(1'b1, 7'h12, mk_entry(9'h000, 8'd5, 16'h0ABC, 1'b1));
      step();
      look_once(32'h0012_3456, 8'd5, h);
      check("fill_hit", h, 1'b1);
      check("fill_padr", last_padr, 32'h0ABC_3456);

      // Miss suppression and hold expiry
      p0 = pulses;
      for (int k = 0; k < 10; k++) begin
         idle();
         set_lookup(32'h0045_6789, 8'd5, 6'd4, 2'd2);
         step();
      end
      idle();
      step();
      check("suppress_pulses", pulses - p0, 1);
      while (cyc < last_miss_cyc + 62) begin
         idle();
         step();
      end
      p0 = pulses;
      set_lookup(32'h0045_6789, 8'd5, 6'd4, 2'd2);
      step();
      set_lookup(32'h0045_6789, 8'd5, 6'd4, 2'd2);
      step();
      check("hold_edge", pulses - p0, 0);
      idle();
      step();
      check("hold_expire", pulses - p0, 1);

      // Same-cycle fill
      set_lookup(32'h0078_9ABC, 8'd7, 6'd9, 2'd3);
      step();
      idle();
      set_fill(1'b0, 7'h78, mk_entry(9'h000, 8'd7, 16'h0123, 1'b1));
      p0 = pulses;
      step();
      check("samecyc_nomiss", pulses - p0, 0);
      look_once(32'h0078_9ABC, 8'd7, h);
      check("samecyc_hit", h, 1'b1);
      check("samecyc_padr", last_padr, 32'h0123_9ABC);

      // ASID flush, then flush_all
      a = 32'h02A0_1111;
      idle();
      set_fill(1'b0, 7'h20, mk_entry(9'h005, 8'd5, 16'h0555, 1'b1));
      step();
      set_fill(1'b1, 7'h20, mk_entry(9'h005, 8'd6, 16'h0666, 1'b1));
      step();
      idle();
      flush_asid_v = 1'b1;
      flush_asid   = 8'd5;
      step();
      look_once(a, 8'd5, h);
      check("asidflush_a5", h, 1'b0);
      look_once(a, 8'd6, h);
      check("asidflush_a6", h, 1'b1);
      check("asidflush_padr", last_padr, 32'h0666_1111);
      idle();
      flush_all = 1'b1;
      step();
      look_once(a, 8'd6, h);
      check("flushall_a6", h, 1'b0);
      look_once(32'h0078_9ABC, 8'd7, h);
      check("flushall_other", h, 1'b0);

      // Async reset with a result in flight
      idle();
      set_fill(1'b1, 7'h12, mk_entry(9'h000, 8'd5, 16'h0ABC, 1'b1));
      step();
      look_once(32'h0012_3456, 8'd5, h);
      check("prereset_hit", h, 1'b1);
      idle();
      set_lookup(32'h0012_3456, 8'd5, 6'd2, 2'd0);
      @(posedge clk);
      #1;
      check("rst_inflight_v", res_v, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_res_v", res_v, 1'b0);
      check("rst_res_hit", res_hit, 1'b0);
      check("rst_res_padr", res_padr, 32'h0);
      check("rst_tlbmiss", tlbmiss, 1'b0);
      check("rst_missadr", tlb_missadr, 32'h0);
      model_reset();
      @(negedge clk);
      idle();
      @(negedge clk);
      rst = 1'b1;
      look_once(32'h0012_3456, 8'd5, h);
      check("postrst_miss", h, 1'b0);
      look_once(32'h0078_9ABC, 8'd7, h);
      check("postrst_miss2", h, 1'b0);

      // Randomized traffic over a small address/ASID pool so hits, conflicts and flushes mix
      for (int k = 0; k < 1500; k++) begin
         idle();
         if ($urandom % 4 != 0)
            set_lookup({9'($urandom % 3), pick_set(), 16'($urandom)}, 8'(5 + $urandom % 3),
                       6'($urandom), 2'($urandom));
         if ($urandom % 6 == 0)
            set_fill(1'($urandom), pick_set(),
                     mk_entry(9'($urandom % 3), 8'(5 + $urandom % 3), 16'($urandom),
                              ($urandom % 8) != 0));
         flush_all    = ($urandom % 200) == 0;
         flush_asid_v = ($urandom % 100) == 0;
         flush_asid   = 8'(5 + $urandom % 3);
         in_que       = ($urandom % 20) == 0;
         step();
      end
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qupls_dtlb.md
Name: qupls_dtlb

Overview:
- Two-way set-associative data TLB directly upstream of the page-table walker. It translates load/store virtual addresses to physical addresses.
- On a miss it issues a one-cycle tlbmiss request, with address, ASID, ROB id and queue number, into the walker's miss queue.
- It accepts walker TLB writes (tlb_wr / tlb_way / tlb_entryno / tlb_entry) to fill entries.
- Page size is 64 KB: set index = adr[22:16], tag = adr[31:23].

Parameters:
- SETS, 128, number of sets; index width = $clog2(SETS) = 7.
- MISS_HOLD, 63, cycles a pending miss suppresses re-issue of the same miss.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- lookup_v  in  1  lookup request valid.
- lookup_adr  in  address_t  virtual address to translate.
- lookup_asid  in  asid_t  address-space id.
- lookup_id  in  rob_ndx_t  ROB index of requesting op.
- lookup_qn  in  2  requesting queue number.
- res_v  out  1  result valid (one cycle after lookup_v).
- res_hit  out  1  translation hit.
- res_padr  out  physical_address_t  {pte.ppn, adr[15:0]} on hit, else 0.
- res_pte  out  spte_t  matching PTE (rights checked downstream).
- tlbmiss  out  1  one-cycle miss request to walker.
- tlb_missadr  out  address_t  missing virtual address.
- tlb_missasid  out  asid_t  missing ASID.
- tlb_missid  out  rob_ndx_t  ROB id of missing op.
- tlb_missqn  out  2  queue number of missing op.
- in_que  in  1  walker reports miss already queued.
- tlb_wr  in  1  fill write strobe.
- tlb_way  in  1  way to fill.
- tlb_entryno  in  7  set to fill.
- tlb_entry  in  tlb_entry_t  entry: pte, vpn.vpn (9 bits), vpn.asid.
- flush_all  in  1  invalidate all entries.
- flush_asid_v  in  1  invalidate entries of flush_asid.
- flush_asid  in  asid_t  ASID to flush.

Behaviour:
- Reset (rst low, async):
  - Valid bits clear in both ways.
  - res_v, res_hit, tlbmiss = 0; all output buses = 0.
  - Pending-miss register invalid; hold counter = 0.
  - Entry data need not be reset.
- Lookup pipeline, one stage:
  - At the cycle-N edge, register the request and the selected set's two ways.
  - At N+1: res_v = 1 for exactly one cycle.
  - Hit (way w) = valid[w] & pte.v & tag==adr[31:23] & asid==lookup_asid.
  - If both ways match, way 0 wins.
- Miss handling, at N+1 when res_v & ~res_hit:
  - tlbmiss pulses one cycle with the registered adr, asid, id and qn.
  - The pulse is suppressed if the pending-miss register is valid and holds the same {asid, adr[31:16]}.
  - The pulse is suppressed if tlb_wr in the same cycle writes the same set, tag and asid.
  - When issued, the pending register loads {asid, adr[31:16]} and the counter loads MISS_HOLD.
- Pending-miss clear, on any of:
  - tlb_wr matching its index/tag/asid;
  - the counter decrementing to 0;
  - flush_all;
  - flush_asid_v with matching ASID.
  - in_que=1 only reloads the counter; it does not clear pending.
- Fill:
  - tlb_wr writes tlb_entry into [tlb_way][tlb_entryno] and sets valid.
  - The write is visible to lookups sampled the following cycle; there is no same-cycle bypass.
- Flush:
  - flush_all clears every valid bit next cycle.
  - flush_asid_v clears valid only where the stored asid matches.
  - A flush and a tlb_wr in the same cycle: the write wins for its entry.
  - A lookup in the flush cycle sees pre-flush contents.
- Back-to-back lookups are accepted every cycle; there is no stall.
- Reset mid-lookup discards the in-flight result (res_v = 0).

Decomposition:
- dtlb_pending_t and MISS_HOLD go in QuplsMmupkg.
- tlb_entry_t, spte_t and asid_t are already in QuplsMmupkg.
- address_t and rob_ndx_t come from QuplsPkg.
- One sub-module, qupls_dtlb_way: a single way, SETS×tlb_entry_t storage plus valid bits, with a sync write port, a registered read port and ASID flush. It is instantiated twice.

Test Plan:
- Cold miss:
  - Stimulus: lookup adr=0x0012_3456, asid=5, id=3, qn=1 after reset.
  - Response: res_v=1, res_hit=0, tlbmiss pulse with missadr=0x0012_3456, asid=5, id=3, qn=1.
- Fill then hit:
  - Stimulus: tlb_wr way=1, entryno=0x12, vpn=0x000, asid=5, pte.v=1, ppn=0xABC; then the same lookup.
  - Response: res_hit=1, res_padr={0xABC, 0x3456}.
- Miss suppression:
  - Stimulus: repeat the cold-miss lookup 10 cycles running.
  - Response: a single tlbmiss pulse.
  - After MISS_HOLD+1 cycles without a fill, the next identical lookup pulses again.
- Same-cycle fill:
  - Stimulus: a lookup miss resolves in the same cycle as a matching tlb_wr.
  - Response: no tlbmiss; the next lookup hits.
- ASID flush:
  - Stimulus: fill entries for asid 5 and asid 6 in the same set, then flush_asid_v with asid 5.
  - Response: the asid 5 lookup misses and the asid 6 lookup still hits.
  - flush_all: both miss.
- Async reset:
  - Stimulus: drop rst while res_v is pending.
  - Response: outputs zero immediately; after release, every lookup misses.
